// File: rtl/ahb_slave_mux_n_if.sv
// rtl/ahb_slave_mux_n_if.sv - bus bundle between the AHB master, ahb_slave_mux_n and its slaves
interface ahb_slave_mux_n_if #(
   parameter int NSLV   = 5,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = 4
);
   logic [ADDR_W-1:0]      i_haddr;
   logic [1:0]             i_htrans;
   logic [NSLV-1:0]        o_sel;
   logic [NSLV*DATA_W-1:0] i_hrdata_flat;
   logic [NSLV-1:0]        i_hready_vec;
   logic [NSLV-1:0]        i_hresp_vec;
   logic [DATA_W-1:0]      o_hrdata;
   logic                   o_hready;
   logic                   o_hresp;
   logic [SEL_W-1:0]       o_dp_idx;
   logic                   o_timeout;

   modport slave (
      input  i_haddr, i_htrans, i_hrdata_flat, i_hready_vec, i_hresp_vec,
      output o_sel, o_hrdata, o_hready, o_hresp, o_dp_idx, o_timeout
   );

   modport master (
      output i_haddr, i_htrans, i_hrdata_flat, i_hready_vec, i_hresp_vec,
      input  o_sel, o_hrdata, o_hready, o_hresp, o_dp_idx, o_timeout
   );
endinterface

// File: rtl/ahb_slave_mux_n.sv
// rtl/ahb_slave_mux_n.sv - AHB-Lite decoder and response mux with default error slave
// Hung-slave watchdog is built only when AHB_MUX_TIMEOUT_EN is defined.
module ahb_slave_mux_n #(
   parameter int NSLV    = 5,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int SEL_LSB = 28,
   parameter int SEL_W   = 4,
   parameter int TIMEOUT = 255
) (
   input logic              i_hclk,
   input logic              i_hreset,
   ahb_slave_mux_n_if.slave bus
);
   typedef enum logic [1:0] {
      DEF_IDLE = 2'd0,
      DEF_ERR1 = 2'd1,
      DEF_ERR2 = 2'd2
   } def_state_e;

   def_state_e        state_q, state_d;
   logic              dp_valid_q, dp_valid_d;
   logic              dp_def_q, dp_def_d;
   logic [SEL_W-1:0]  dp_idx_q, dp_idx_d;

   logic [SEL_W-1:0]  a_idx;
   logic              a_active;
   logic              a_def;
   logic [NSLV-1:0]   sel;
   logic [DATA_W-1:0] slv_hrdata, hrdata;
   logic              slv_hready, slv_hresp;
   logic              hready, hresp;
   logic              fire;
   logic              timeout;

   assign a_idx    = bus.i_haddr[SEL_LSB +: SEL_W];
   assign a_active = bus.i_htrans[1];
   assign a_def    = a_active && (int'(a_idx) >= NSLV);

   always_comb begin
      sel = '0;
      for (int k = 0; k < NSLV; k++) begin
         sel[k] = !i_hreset && a_active && (int'(a_idx) == k);
      end
   end

   always_comb begin
      slv_hrdata = '0;
      slv_hready = 1'b1;
      slv_hresp  = 1'b0;
      for (int k = 0; k < NSLV; k++) begin
         if (int'(dp_idx_q) == k) begin
            slv_hrdata = bus.i_hrdata_flat[k*DATA_W +: DATA_W];
            slv_hready = bus.i_hready_vec[k];
            slv_hresp  = bus.i_hresp_vec[k];
         end
      end
   end

`ifdef AHB_MUX_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
   logic        wait_slv;

   // Only a real-slave phase that is still being passed through can time out.
   always_comb begin
      wait_slv  = (state_q == DEF_IDLE) && dp_valid_q && !dp_def_q && !slv_hready;
      fire      = wait_slv && (cnt_q == 16'(TIMEOUT - 1));
      cnt_d     = wait_slv ? cnt_q + 16'd1 : 16'd0;
      timeout_d = fire;
   end

   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         cnt_q     <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign fire    = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         state_q <= DEF_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DEF_IDLE: if (fire || (hready && a_def)) state_d = DEF_ERR1;
         DEF_ERR1: state_d = DEF_ERR2;
         DEF_ERR2: state_d = a_def ? DEF_ERR1 : DEF_IDLE;
         default:  state_d = DEF_IDLE;
      endcase
   end

   // Error states override the slave mux, which also drops a timed-out slave.
   always_comb begin
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;
      case (state_q)
         DEF_ERR1: begin
            hready = 1'b0;
            hresp  = 1'b1;
         end
         DEF_ERR2: hresp = 1'b1;
         default: begin
            if (dp_valid_q && !dp_def_q) begin
               hready = slv_hready;
               hresp  = slv_hresp;
               hrdata = slv_hrdata;
            end
         end
      endcase
   end

   always_comb begin
      dp_valid_d = hready ? a_active : dp_valid_q;
      dp_def_d   = hready ? a_def    : dp_def_q;
      dp_idx_d   = hready ? a_idx    : dp_idx_q;
   end

   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         dp_valid_q <= 1'b0;
         dp_def_q   <= 1'b0;
         dp_idx_q   <= '0;
      end else begin
         dp_valid_q <= dp_valid_d;
         dp_def_q   <= dp_def_d;
         dp_idx_q   <= dp_idx_d;
      end
   end

   assign bus.o_sel     = sel;
   assign bus.o_hrdata  = hrdata;
   assign bus.o_hready  = hready;
   assign bus.o_hresp   = hresp;
   assign bus.o_dp_idx  = dp_idx_q;
   assign bus.o_timeout = timeout;
endmodule
